// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared FSM state type and Gray encode/decode helpers for the sweep controller
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [31:0] gray_enc(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray_dec(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_encode.sv
// rtl/gray_encode.sv - combinational binary-to-Gray encoder
module gray_encode #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_sweep_ctrl.sv
// rtl/gray_sweep_ctrl.sv - steps a binary/Gray code from one bound to the other under ready/valid flow control
// Optional GRAY_SWEEP_CHECK_EN adds a sticky err output from a decode-back check of every accepted beat.
module gray_sweep_ctrl
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             dir,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_bin,
   output logic [WIDTH-1:0] out_gray,
   output logic             busy,
   output logic             done
`ifdef GRAY_SWEEP_CHECK_EN
   ,
   output logic             err
`endif
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] end_q, end_d;
   logic             dir_q, dir_d;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      end_d   = end_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               dir_d   = dir;
               cur_d   = dir ? hi : lo;
               end_d   = dir ? lo : hi;
            end
         end
         RUN: begin
            // abort wins over a beat accepted in the same cycle
            if (abort) begin
               state_d = IDLE;
            end else if (out_ready) begin
               if (cur_q == end_q) begin
                  state_d = DONE;
               end else begin
                  cur_d = dir_q ? (cur_q - WIDTH'(1)) : (cur_q + WIDTH'(1));
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         end_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         dir_q   <= dir_d;
      end
   end

   assign out_valid = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign out_bin   = cur_q;

   gray_encode #(
      .WIDTH (WIDTH)
   ) u_gray_encode (
      .bin  (cur_q),
      .gray (out_gray)
   );

`ifdef GRAY_SWEEP_CHECK_EN
   logic        err_q, err_d;
   logic [31:0] dec_w;

   always_comb begin
      dec_w = gray_dec(32'(out_gray));
      err_d = err_q;
      if (state_q == RUN && out_ready && dec_w != 32'(out_bin)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// tb/tb_gray_sweep_ctrl.sv - self-checking bench for gray_sweep_ctrl against a sequence-list reference model
module tb_gray_sweep_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [3:0] lo;
   logic [3:0] hi;
   logic       dir;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] out_bin;
   logic [3:0] out_gray;
   logic       busy;
   logic       done;
`ifdef GRAY_SWEEP_CHECK_EN
   logic       err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   gray_sweep_ctrl #(
      .WIDTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .lo        (lo),
      .hi        (hi),
      .dir       (dir),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_bin   (out_bin),
      .out_gray  (out_gray),
      .busy      (busy),
      .done      (done)
`ifdef GRAY_SWEEP_CHECK_EN
      ,
      .err       (err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int gray_of(input int b);
      return (b ^ (b >> 1)) & 15;
   endfunction

   task automatic check_err_clear();
`ifdef GRAY_SWEEP_CHECK_EN
      chk("err", 32'(err), 32'd0);
`endif
   endtask

   // mode 0: always ready, 1: random ready, 2: stall 3 cycles on stall_bin
   task automatic sweep(input int lo_i, input int hi_i, input bit dir_i,
                        input int mode, input int abort_at, input int stall_bin);
      int  exp_q[$];
      int  n;
      int  idx;
      int  cyc;
      int  stall;
      bit  r;
      bit  aborted;
      n = ((hi_i - lo_i) & 15) + 1;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(dir_i ? ((hi_i - k) & 15) : ((lo_i + k) & 15));
      end

      @(negedge clk);
      start     = 1'b1;
      abort     = 1'($urandom_range(0, 1));
      lo        = 4'(lo_i);
      hi        = 4'(hi_i);
      dir       = dir_i;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      lo    = 4'($urandom_range(0, 15));
      hi    = 4'($urandom_range(0, 15));
      dir   = 1'($urandom_range(0, 1));

      idx = 0; cyc = 0; stall = 0; aborted = 1'b0;
      while (idx < n && cyc < 400) begin
         chk("valid", 32'(out_valid), 32'd1);
         chk("busy", 32'(busy), 32'd1);
         chk("done_run", 32'(done), 32'd0);
         chk("bin", 32'(out_bin), 32'(exp_q[idx]));
         chk("gray", 32'(out_gray), 32'(gray_of(exp_q[idx])));
         if (mode == 0) r = 1'b1;
         else if (mode == 1) r = 1'($urandom_range(0, 1));
         else if (exp_q[idx] == stall_bin && stall < 3) begin r = 1'b0; stall++; end
         else r = 1'b1;
         start     = 1'($urandom_range(0, 1));
         out_ready = r;
         if (idx == abort_at) begin
            abort   = 1'b1;
            aborted = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (aborted) break;
         if (r) idx++;
      end

      abort = 1'b0;
      if (aborted) begin
         start = 1'b0;
         chk("abort_valid", 32'(out_valid), 32'd0);
         chk("abort_busy", 32'(busy), 32'd0);
         chk("abort_done", 32'(done), 32'd0);
         @(negedge clk);
         chk("abort_done2", 32'(done), 32'd0);
         chk("abort_valid2", 32'(out_valid), 32'd0);
      end else begin
         if (cyc >= 400) chk("timeout", 32'(idx), 32'(n));
         chk("done_pulse", 32'(done), 32'd1);
         chk("done_valid", 32'(out_valid), 32'd0);
         chk("done_busy", 32'(busy), 32'd0);
         start = 1'($urandom_range(0, 1));
         abort = 1'($urandom_range(0, 1));
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         chk("done_end", 32'(done), 32'd0);
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end
      check_err_clear();
   endtask

   initial begin
      int a, b;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      lo        = '0;
      hi        = '0;
      dir       = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bin", 32'(out_bin), 32'd0);
      chk("rst_gray", 32'(out_gray), 32'd0);
      check_err_clear();
      @(negedge clk);
      rst = 1'b0;

      sweep(0, 15, 1'b0, 0, -1, -1);
      sweep(2, 5, 1'b1, 0, -1, -1);
      sweep(14, 1, 1'b0, 0, -1, -1);
      sweep(0, 7, 1'b0, 2, -1, 3);
      sweep(0, 9, 1'b0, 0, 4, -1);
      sweep(5, 5, 1'b0, 1, -1, -1);
      sweep(9, 9, 1'b1, 0, -1, -1);
      sweep(12, 3, 1'b1, 1, -1, -1);
      sweep(3, 12, 1'b1, 1, -1, -1);
      for (int t = 0; t < 20; t++) begin
         a = $urandom_range(0, 15);
         b = $urandom_range(0, 15);
         sweep(a, b, 1'($urandom_range(0, 1)), 1,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1, -1);
      end

      @(negedge clk);
      start = 1'b1; lo = 4'd0; hi = 4'd9; dir = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_bin", 32'(out_bin), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_bin", 32'(out_bin), 32'd0);
      chk("mid_rst_gray", 32'(out_gray), 32'd0);
      check_err_clear();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(out_valid), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
         chk("post_rst_done", 32'(done), 32'd0);
      end
      sweep(1, 4, 1'b0, 0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
